// File: rtl/fifo_port_scheduler.sv
// fifo_port_scheduler: lets NREQ requesters share one adder datapath.
// Issue side grants the input FIFO round-robin and records each issuer's ID
// in an in-order tag queue. Return side reads each result from the return
// FIFO and presents it to the requester at the head of the tag queue.

module fifo_port_scheduler #(
    parameter int unsigned NREQ       = 4,
    parameter int unsigned DW         = 32,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned TAG_DEPTH  = 16
) (
    input  logic                         clk_main_a0,
    input  logic                         rst_main_n_sync,
    input  logic [NREQ-1:0]              req_valid,
    input  logic [NREQ*DW-1:0]           req_data,
    output logic [NREQ-1:0]              req_ready,
    output logic                         fifo_in_wr,
    output logic [DW-1:0]                fifo_in_din,
    input  logic [7:0]                   fifo_in_size,
    input  logic                         fifo_out_empty,
    output logic                         fifo_out_rd,
    input  logic [DW-1:0]                fifo_out_dout,
    output logic [NREQ-1:0]              rsp_valid,
    output logic [DW-1:0]                rsp_data,
    input  logic [NREQ-1:0]              rsp_ready,
    output logic [$clog2(TAG_DEPTH):0]   outstanding,
    output logic                         orphan_err
);

    localparam int unsigned IdW  = $clog2(NREQ);
    localparam int unsigned PtrW = $clog2(TAG_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {
        RIdle,
        RWait,
        RCapture,
        RPresent
    } ret_state_e;

    // Issue-side state
    logic            fifo_in_wr_q;
    logic [DW-1:0]   fifo_in_din_q;
    logic [IdW-1:0]  last_grant_q;

    // Tag queue state
    logic [IdW-1:0]  tag_mem [TAG_DEPTH];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic [IdW-1:0]  head_tag;

    // Return-side state
    ret_state_e      state_q, state_d;
    logic            fifo_out_rd_q, fifo_out_rd_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_data_q, rsp_data_d;
    logic            orphan_q, orphan_d;

    logic            can_issue;
    logic            push;
    logic            pop;
    logic [IdW-1:0]  grant_idx;
    logic [31:0]     credit_sum;

    // A write strobed last cycle is not yet counted in fifo_in_size, so credit it here.
    assign credit_sum = {24'd0, fifo_in_size} + {31'd0, fifo_in_wr_q};
    assign can_issue  = (credit_sum < FIFO_DEPTH) && (count_q < CntW'(TAG_DEPTH));
    assign head_tag   = tag_mem[rd_ptr_q];

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        logic [IdW-1:0] cand;
        cand      = '0;
        grant_idx = last_grant_q;
        push      = 1'b0;
        req_ready = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = last_grant_q + IdW'(k);
            if (can_issue && !push && req_valid[cand]) begin
                push      = 1'b1;
                grant_idx = cand;
            end
        end
        if (push) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Register the input FIFO write and remember who was granted.
    always_ff @(posedge clk_main_a0 or negedge rst_main_n_sync) begin
        if (!rst_main_n_sync) begin
            fifo_in_wr_q  <= 1'b0;
            fifo_in_din_q <= '0;
            last_grant_q  <= IdW'(NREQ - 1);
        end else begin
            fifo_in_wr_q <= push;
            if (push) begin
                fifo_in_din_q <= req_data[grant_idx*DW +: DW];
                last_grant_q  <= grant_idx;
            end
        end
    end

    // Tag storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk_main_a0) begin
        if (push) begin
            tag_mem[wr_ptr_q] <= grant_idx;
        end
    end

    // Tag queue pointers and occupancy; push and pop may coincide.
    always_ff @(posedge clk_main_a0 or negedge rst_main_n_sync) begin
        if (!rst_main_n_sync) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Return FSM next-state and registered-output logic.
    always_comb begin
        state_d       = state_q;
        fifo_out_rd_d = 1'b0;
        rsp_valid_d   = rsp_valid_q;
        rsp_data_d    = rsp_data_q;
        orphan_d      = orphan_q;
        pop           = 1'b0;
        unique case (state_q)
            RIdle: begin
                if (!fifo_out_empty) begin
                    fifo_out_rd_d = 1'b1;
                    state_d       = RWait;
                end
            end
            RWait: begin
                // Read strobe is high this cycle; data follows next cycle.
                state_d = RCapture;
            end
            RCapture: begin
                if (count_q != '0) begin
                    rsp_data_d            = fifo_out_dout;
                    rsp_valid_d           = '0;
                    rsp_valid_d[head_tag] = 1'b1;
                    state_d               = RPresent;
                end else begin
                    // Result with no issuer on record: drop it and flag.
                    orphan_d = 1'b1;
                    state_d  = RIdle;
                end
            end
            RPresent: begin
                if (rsp_ready[head_tag]) begin
                    rsp_valid_d = '0;
                    pop         = 1'b1;
                    state_d     = RIdle;
                end
            end
            default: state_d = RIdle;
        endcase
    end

    // Return FSM state and output registers.
    always_ff @(posedge clk_main_a0 or negedge rst_main_n_sync) begin
        if (!rst_main_n_sync) begin
            state_q       <= RIdle;
            fifo_out_rd_q <= 1'b0;
            rsp_valid_q   <= '0;
            rsp_data_q    <= '0;
            orphan_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            fifo_out_rd_q <= fifo_out_rd_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            orphan_q      <= orphan_d;
        end
    end

    assign fifo_in_wr  = fifo_in_wr_q;
    assign fifo_in_din = fifo_in_din_q;
    assign fifo_out_rd = fifo_out_rd_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign outstanding = count_q;
    assign orphan_err  = orphan_q;

endmodule

// File: tb/tb_fifo_port_scheduler.sv
// Bench for fifo_port_scheduler: models the input FIFO, adder (+1) and return
// FIFO with queues, and scoreboards grants, writes and routed results.

module tb_fifo_port_scheduler;

    localparam int NREQ = 4;
    localparam int DW   = 32;
    localparam int FD   = 16;
    localparam int TD   = 16;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              fifo_in_wr;
    logic [DW-1:0]     fifo_in_din;
    logic [7:0]        fifo_in_size;
    logic              fifo_out_empty;
    logic              fifo_out_rd;
    logic [DW-1:0]     fifo_out_dout;
    logic [NREQ-1:0]   rsp_valid;
    logic [DW-1:0]     rsp_data;
    logic [NREQ-1:0]   rsp_ready;
    logic [4:0]        outstanding;
    logic              orphan_err;

    fifo_port_scheduler #(
        .NREQ(NREQ), .DW(DW), .FIFO_DEPTH(FD), .TAG_DEPTH(TD)
    ) dut (
        .clk_main_a0    (clk),
        .rst_main_n_sync(rst_n),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .fifo_in_wr     (fifo_in_wr),
        .fifo_in_din    (fifo_in_din),
        .fifo_in_size   (fifo_in_size),
        .fifo_out_empty (fifo_out_empty),
        .fifo_out_rd    (fifo_out_rd),
        .fifo_out_dout  (fifo_out_dout),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .rsp_ready      (rsp_ready),
        .outstanding    (outstanding),
        .orphan_err     (orphan_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // External FIFO + adder model
    logic [DW-1:0] in_q[$];
    logic [DW-1:0] out_q[$];
    int            adder_pct = 100;
    int            vmode     = 0;  // 0 idle, 1 all valid, 2 random, 3 hold
    int            rmode     = 1;  // 0 never ready, 1 always, 2 random

    // Reference model state
    bit            mon_en     = 1'b0;
    int            last_grant_m;
    int            out_m;
    bit            wr_pend_m;
    logic [DW-1:0] exp_wr[$];
    int            exp_id[$];
    logic [DW-1:0] exp_dat[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare DUT against the reference model mid-cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            int            g;
            int            idx;
            logic [3:0]    exp_ready;
            bit            can;
            logic [DW-1:0] w;

            chk("outstanding", 64'(outstanding), 64'(out_m));

            chk("fifo_in_wr", 64'(fifo_in_wr), 64'(wr_pend_m));
            if (fifo_in_wr) begin
                if (exp_wr.size() == 0) begin
                    chk("unexpected_write", 64'(1), 64'(0));
                end else begin
                    w = exp_wr.pop_front();
                    chk("fifo_in_din", 64'(fifo_in_din), 64'(w));
                end
            end

            can       = ((in_q.size() + int'(wr_pend_m)) < FD) && (out_m < TD);
            exp_ready = '0;
            g         = -1;
            if (can) begin
                for (int k = 1; k <= NREQ; k++) begin
                    idx = (last_grant_m + k) % NREQ;
                    if (g < 0 && req_valid[idx]) g = idx;
                end
            end
            if (g >= 0) exp_ready[g] = 1'b1;
            chk("req_ready", 64'(req_ready), 64'(exp_ready));

            if (rsp_valid != '0) begin
                if (exp_id.size() == 0) begin
                    chk("unexpected_rsp_valid", 64'(rsp_valid), 64'(0));
                end else begin
                    chk("rsp_valid", 64'(rsp_valid), 64'(4'b0001 << exp_id[0]));
                    chk("rsp_data", 64'(rsp_data), 64'(exp_dat[0]));
                    if (rsp_ready[exp_id[0]]) begin
                        void'(exp_id.pop_front());
                        void'(exp_dat.pop_front());
                        out_m--;
                    end
                end
            end

            if (g >= 0) begin
                w = req_data[g*DW +: DW];
                exp_wr.push_back(w);
                exp_id.push_back(g);
                exp_dat.push_back(w + 32'd1);
                last_grant_m = g;
                out_m++;
                wr_pend_m = 1'b1;
            end else begin
                wr_pend_m = 1'b0;
            end
        end
    end

    // One clock: sample DUT strobes, advance FIFO/adder model, drive new stimulus.
    task automatic step();
        logic          wr_s;
        logic          rd_s;
        logic [DW-1:0] din_s;
        @(negedge clk);
        wr_s  = fifo_in_wr;
        rd_s  = fifo_out_rd;
        din_s = fifo_in_din;
        @(posedge clk);
        #1;
        if (rd_s && out_q.size() > 0) fifo_out_dout = out_q.pop_front();
        if (wr_s) in_q.push_back(din_s);
        if (in_q.size() > 0 && int'($urandom_range(99)) < adder_pct)
            out_q.push_back(in_q.pop_front() + 32'd1);
        fifo_in_size   = 8'(in_q.size());
        fifo_out_empty = (out_q.size() == 0);
        case (vmode)
            0: req_valid = '0;
            1: req_valid = '1;
            2: req_valid = 4'($urandom);
            default: ;
        endcase
        if (vmode != 3) req_data = {$urandom, $urandom, $urandom, $urandom};
        case (rmode)
            0: rsp_ready = '0;
            1: rsp_ready = '1;
            default: rsp_ready = 4'($urandom);
        endcase
    endtask

    initial begin
        int n;
        rst_n          = 1'b0;
        req_valid      = '0;
        req_data       = '0;
        rsp_ready      = '0;
        fifo_in_size   = 8'd0;
        fifo_out_empty = 1'b1;
        fifo_out_dout  = '0;
        last_grant_m   = NREQ - 1;
        out_m          = 0;
        wr_pend_m      = 1'b0;
        #23;
        chk("reset_fifo_in_wr", 64'(fifo_in_wr), 64'(0));
        chk("reset_fifo_out_rd", 64'(fifo_out_rd), 64'(0));
        chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("reset_rsp_data", 64'(rsp_data), 64'(0));
        chk("reset_outstanding", 64'(outstanding), 64'(0));
        chk("reset_orphan_err", 64'(orphan_err), 64'(0));
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Single transaction from requester 0.
        vmode = 3; rmode = 1;
        step();
        req_valid = 4'b0001;
        req_data  = '0;
        req_data[31:0] = 32'h5;
        step();
        req_valid = '0;
        for (int i = 0; i < 12; i++) step();

        // Saturate: stall adder and results, all requesters valid.
        vmode = 1; rmode = 0; adder_pct = 0;
        for (int i = 0; i < 40; i++) step();
        adder_pct = 100;
        for (int i = 0; i < 40; i++) step();
        rmode = 2;
        for (int i = 0; i < 200; i++) step();

        // Random traffic.
        vmode = 2; adder_pct = 60;
        for (int i = 0; i < 1500; i++) step();

        // Drain everything.
        vmode = 0; rmode = 1; adder_pct = 100;
        n = 0;
        while ((exp_id.size() > 0 || in_q.size() > 0 || out_q.size() > 0) && n < 3000) begin
            step();
            n++;
        end
        chk("drain_pending", 64'(exp_id.size()), 64'(0));
        for (int i = 0; i < 6; i++) step();

        // Orphan result: nothing outstanding.
        out_q.push_back(32'hDEAD_BEEF);
        fifo_out_empty = 1'b0;
        n = 0;
        while (!orphan_err && n < 20) begin
            step();
            n++;
        end
        chk("orphan_err", 64'(orphan_err), 64'(1));
        for (int i = 0; i < 6; i++) step();
        chk("orphan_word_consumed", 64'(out_q.size()), 64'(0));
        chk("orphan_outstanding", 64'(outstanding), 64'(0));

        // Reset while a result is being presented.
        vmode = 3; rmode = 0;
        req_valid = 4'b0010;
        req_data  = {$urandom, $urandom, $urandom, $urandom};
        step();
        req_valid = '0;
        n = 0;
        while (rsp_valid == '0 && n < 40) begin
            step();
            n++;
        end
        chk("present_before_reset", 64'(rsp_valid), 64'(4'b0010));
        mon_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_outstanding", 64'(outstanding), 64'(0));
        chk("rst_orphan_err", 64'(orphan_err), 64'(0));
        chk("rst_rsp_data", 64'(rsp_data), 64'(0));
        chk("rst_fifo_out_rd", 64'(fifo_out_rd), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_port_scheduler.md
Name: fifo_port_scheduler

Overview:
Shares the single adder datapath (cl_to_fifotest input FIFO, user adder, fifotest_to_cl return FIFO) among NREQ requesters. Grants write access round-robin and records each issuing requester's ID in an in-order tag queue. Routes each returned result back to the requester that issued the matching input. The adder returns exactly one result per input, in order. Sits between the register/host-facing request logic and the two FIFO_Shanquan instances.

Parameters:
NREQ, 4, number of requesters (power of 2, ≥2)
DW, 32, data word width
FIFO_DEPTH, 16, depth of the input FIFO (credit limit against fifo_in_size)
TAG_DEPTH, 16, max outstanding inputs without results (power of 2)

Ports:
clk_main_a0  in  1  main clock
rst_main_n_sync  in  1  reset; asynchronous assert, active-low
req_valid  in  NREQ  per-requester word available
req_data  in  NREQ*DW  requester i word at [i*DW +: DW]
req_ready  out  NREQ  one-hot grant, combinational
fifo_in_wr  out  1  input FIFO write strobe, registered
fifo_in_din  out  DW  input FIFO write data, registered
fifo_in_size  in  8  input FIFO occupancy
fifo_out_empty  in  1  return FIFO empty
fifo_out_rd  out  1  return FIFO read strobe, registered, 1-cycle pulse
fifo_out_dout  in  DW  return FIFO data, valid the cycle after fifo_out_rd is high
rsp_valid  out  NREQ  one-hot result valid for the owning requester
rsp_data  out  DW  result word, shared bus
rsp_ready  in  NREQ  requester accepts result
outstanding  out  $clog2(TAG_DEPTH)+1  tag queue occupancy
orphan_err  out  1  sticky: result arrived with empty tag queue

Behaviour:
Reset (rst_main_n_sync low, asynchronous):
- fifo_in_wr=0, fifo_in_din=0, fifo_out_rd=0, rsp_valid=0, rsp_data=0.
- outstanding=0, orphan_err=0, last_grant=NREQ-1, return FSM in R_IDLE.
- Reset mid-transaction drops all in-flight state. The external FIFOs share this reset.

Issue side:
- can_issue = (fifo_in_size + fifo_in_wr < FIFO_DEPTH) && (outstanding < TAG_DEPTH).
- The fifo_in_wr term credits the registered write not yet reflected in size.
- When can_issue, req_ready asserts one-hot on the first requester with req_valid, searching from last_grant+1 and wrapping modulo NREQ. Otherwise req_ready=0.
- Handshake (req_valid & req_ready on requester g) causes, at the next edge:
  - fifo_in_wr<=1, fifo_in_din<=req_data[g]
  - g pushed into the tag queue
  - last_grant<=g
- No handshake: fifo_in_wr<=0, last_grant holds.
- Sustained throughput is 1 word/cycle while credits allow.

Return side, FSM states R_IDLE, R_WAIT, R_CAPTURE, R_PRESENT:
- R_IDLE: if !fifo_out_empty, set fifo_out_rd<=1 and go to R_WAIT.
- R_WAIT: fifo_out_rd is high this cycle; go to R_CAPTURE. fifo_out_rd<=0.
- R_CAPTURE:
  - Tag queue non-empty: rsp_data<=fifo_out_dout, rsp_valid<=onehot(head), go to R_PRESENT.
  - Tag queue empty: discard the word, orphan_err<=1, go to R_IDLE.
- R_PRESENT: hold rsp_data and rsp_valid until rsp_ready[head]. Then rsp_valid<=0, pop the tag queue, go to R_IDLE.
- rsp_ready bits of non-owning requesters are ignored.
- Minimum 4 cycles per result.

Tag queue:
- Circular buffer of TAG_DEPTH entries of $clog2(NREQ) bits.
- Push and pop in the same cycle: both occur, outstanding unchanged.
- Pointers wrap modulo TAG_DEPTH.
- outstanding is the registered count.

Test Plan:
- Req0 sends 0x0000_0005; FIFO+adder model returns 0x0000_0006 -> fifo_in_wr 1 cycle after handshake with din=0x5; rsp_valid=4'b0001, rsp_data=0x6; outstanding returns to 0 after rsp_ready[0].
- All four req_valid held high, last_grant=3 -> grant order 0,1,2,3,0 on consecutive cycles. From last_grant=2 -> order 3,0,1,2.
- fifo_in_size=15 with fifo_in_wr=1 (FIFO_DEPTH=16) -> req_ready=0. Next cycle size=15, wr=0 -> one grant.
- 16 words issued, no results -> outstanding=16, req_ready=0. One result accepted -> outstanding=15, grants resume.
- Req2 then req1 issue, results 0xA then 0xB -> rsp_valid=4'b0100 with 0xA first, then 4'b0010 with 0xB. rsp_ready[1] asserted during req2's response is ignored.
- outstanding=0 with fifo_out_empty=0 -> one rd pulse, orphan_err=1, no rsp_valid. Reset mid-R_PRESENT -> rsp_valid=0, outstanding=0, orphan_err=0 immediately.
